// File: rtl/exe_mem_stage.sv
// Execute stage (operand forwarding mux + ALU) and the EXE/MEM pipeline register.
// Optional macro FORWARDING_EN enables forwarding selects and the fwd_count statistic.
module exe_mem_stage #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic [3:0]              EXE_CMD,
  input  logic [WORD_LEN-1:0]     val1_EXE,
  input  logic [WORD_LEN-1:0]     val2_EXE,
  input  logic [WORD_LEN-1:0]     ST_val_EXE,
  input  logic [REG_ADDR_LEN-1:0] dest_EXE,
  input  logic                    WB_EN_EXE,
  input  logic                    MEM_R_EN_EXE,
  input  logic                    MEM_W_EN_EXE,
  input  logic [1:0]              val1_sel,
  input  logic [1:0]              val2_sel,
  input  logic [1:0]              ST_val_sel,
  input  logic [WORD_LEN-1:0]     ALU_res_fwd_MEM,
  input  logic [WORD_LEN-1:0]     WB_value,
  output logic [WORD_LEN-1:0]     ALU_res_MEM,
  output logic [WORD_LEN-1:0]     ST_val_MEM,
  output logic [REG_ADDR_LEN-1:0] dest_MEM,
  output logic                    WB_EN_MEM,
  output logic                    MEM_R_EN_MEM,
  output logic                    MEM_W_EN_MEM,
  output logic [15:0]             fwd_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_NOR = 4'd4;
  localparam logic [3:0] CMD_XOR = 4'd5;
  localparam logic [3:0] CMD_SLL = 4'd6;
  localparam logic [3:0] CMD_SRA = 4'd7;
  localparam logic [3:0] CMD_SRL = 4'd8;

  logic [1:0] sel1, sel2, sel_st;

`ifdef FORWARDING_EN
  assign sel1   = val1_sel;
  assign sel2   = val2_sel;
  assign sel_st = ST_val_sel;
`else
  // Without forwarding the hazard unit stalls, so operands always come from ID/EXE.
  assign sel1   = 2'd0;
  assign sel2   = 2'd0;
  assign sel_st = 2'd0;
  logic unused_fwd;
  assign unused_fwd = ^{val1_sel, val2_sel, ST_val_sel};
`endif

  function automatic logic [WORD_LEN-1:0] fwd_mux(
    input logic [1:0]          sel,
    input logic [WORD_LEN-1:0] id_val,
    input logic [WORD_LEN-1:0] mem_val,
    input logic [WORD_LEN-1:0] wb_val
  );
    case (sel)
      2'd1:    fwd_mux = mem_val;
      2'd2:    fwd_mux = wb_val;
      default: fwd_mux = id_val;
    endcase
  endfunction

  function automatic logic [1:0] is_fwd(input logic [1:0] sel);
    is_fwd = {1'b0, (sel == 2'd1) || (sel == 2'd2)};
  endfunction

  logic [WORD_LEN-1:0] op_a, op_b, st_val, alu_res;
  logic [SHAMT_W-1:0]  shamt;

  assign op_a   = fwd_mux(sel1,   val1_EXE,   ALU_res_fwd_MEM, WB_value);
  assign op_b   = fwd_mux(sel2,   val2_EXE,   ALU_res_fwd_MEM, WB_value);
  assign st_val = fwd_mux(sel_st, ST_val_EXE, ALU_res_fwd_MEM, WB_value);
  assign shamt  = op_b[SHAMT_W-1:0];

  // ALU; undefined commands produce zero.
  always_comb begin
    alu_res = '0;
    case (EXE_CMD)
      CMD_ADD: alu_res = op_a + op_b;
      CMD_SUB: alu_res = op_a - op_b;
      CMD_AND: alu_res = op_a & op_b;
      CMD_OR:  alu_res = op_a | op_b;
      CMD_NOR: alu_res = ~(op_a | op_b);
      CMD_XOR: alu_res = op_a ^ op_b;
      CMD_SLL: alu_res = op_a << shamt;
      CMD_SRA: alu_res = WORD_LEN'($signed(op_a) >>> shamt);
      CMD_SRL: alu_res = op_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  // EXE/MEM register: reset > flush (bubble) > freeze (hold) > load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ALU_res_MEM  <= '0;
      ST_val_MEM   <= '0;
      dest_MEM     <= '0;
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      MEM_W_EN_MEM <= 1'b0;
    end else if (flush) begin
      ALU_res_MEM  <= '0;
      ST_val_MEM   <= '0;
      dest_MEM     <= '0;
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      MEM_W_EN_MEM <= 1'b0;
    end else if (!freeze) begin
      ALU_res_MEM  <= alu_res;
      ST_val_MEM   <= st_val;
      dest_MEM     <= dest_EXE;
      WB_EN_MEM    <= WB_EN_EXE;
      MEM_R_EN_MEM <= MEM_R_EN_EXE;
      MEM_W_EN_MEM <= MEM_W_EN_EXE;
    end
  end

`ifdef FORWARDING_EN
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cnt_inc;
  logic [CNT_W:0]   cnt_sum;

  assign cnt_inc = is_fwd(sel1) + is_fwd(sel2) + is_fwd(sel_st);
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(cnt_inc);

  // Saturating count of forwarded operands on load cycles only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!flush && !freeze) begin
      cnt_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  assign fwd_count = cnt_q;
`else
  assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed self-checking bench for exe_mem_stage; expectations follow FORWARDING_EN.
module tb_exe_mem_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1_EXE, val2_EXE, ST_val_EXE;
  logic [4:0]  dest_EXE;
  logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE;
  logic [1:0]  val1_sel, val2_sel, ST_val_sel;
  logic [31:0] ALU_res_fwd_MEM, WB_value;
  logic [31:0] ALU_res_MEM, ST_val_MEM;
  logic [4:0]  dest_MEM;
  logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
  logic [15:0] fwd_count;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_cnt;

  exe_mem_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .EXE_CMD(EXE_CMD),
    .val1_EXE(val1_EXE), .val2_EXE(val2_EXE), .ST_val_EXE(ST_val_EXE),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .MEM_W_EN_EXE(MEM_W_EN_EXE), .val1_sel(val1_sel), .val2_sel(val2_sel),
    .ST_val_sel(ST_val_sel), .ALU_res_fwd_MEM(ALU_res_fwd_MEM), .WB_value(WB_value),
    .ALU_res_MEM(ALU_res_MEM), .ST_val_MEM(ST_val_MEM), .dest_MEM(dest_MEM),
    .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
    EXE_CMD = cmd; val1_EXE = a; val2_EXE = b;
    tick();
    check(tag, ALU_res_MEM, exp);
  endtask

  initial begin
    // Reset held two cycles with busy inputs
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    EXE_CMD = 4'd0; val1_EXE = 32'h1111_1111; val2_EXE = 32'h2222_2222;
    ST_val_EXE = 32'h3333_3333; dest_EXE = 5'd9;
    WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b1; MEM_W_EN_EXE = 1'b1;
    val1_sel = 2'd1; val2_sel = 2'd2; ST_val_sel = 2'd1;
    ALU_res_fwd_MEM = 32'h4444_4444; WB_value = 32'h5555_5555;
    tick(); tick();
    check("rst_alu",   ALU_res_MEM, 32'h0);
    check("rst_st",    ST_val_MEM, 32'h0);
    check("rst_dest",  32'(dest_MEM), 32'h0);
    check("rst_wb",    32'(WB_EN_MEM), 32'h0);
    check("rst_mr",    32'(MEM_R_EN_MEM), 32'h0);
    check("rst_mw",    32'(MEM_W_EN_MEM), 32'h0);
    check("rst_cnt",   32'(fwd_count), 32'h0);
    rst = 1'b1;
    exp_cnt = 16'd0;

    // Operand forwarding from MEM and WB
    val1_EXE = 32'd5; val2_EXE = 32'd1; ALU_res_fwd_MEM = 32'd7; WB_value = 32'd9;
    val1_sel = 2'd1; val2_sel = 2'd2; ST_val_sel = 2'd0; ST_val_EXE = 32'h1234;
    EXE_CMD = 4'd0; dest_EXE = 5'd3; WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b0; MEM_W_EN_EXE = 1'b0;
    tick();
    exp_cnt = FWD ? 16'd2 : 16'd0;
    check("fwd_alu",  ALU_res_MEM, FWD ? 32'd16 : 32'd6);
    check("fwd_cnt",  32'(fwd_count), 32'(exp_cnt));
    check("fwd_st",   ST_val_MEM, 32'h1234);
    check("fwd_dest", 32'(dest_MEM), 32'd3);
    check("fwd_wb",   32'(WB_EN_MEM), 32'd1);

    // Store value forwarded from WB
    val1_sel = 2'd0; val2_sel = 2'd0; ST_val_sel = 2'd2;
    WB_value = 32'hDEAD_BEEF; ST_val_EXE = 32'h55; MEM_W_EN_EXE = 1'b1;
    tick();
    exp_cnt = FWD ? 16'd3 : 16'd0;
    check("stfwd_st",  ST_val_MEM, FWD ? 32'hDEAD_BEEF : 32'h55);
    check("stfwd_mw",  32'(MEM_W_EN_MEM), 32'd1);
    check("stfwd_alu", ALU_res_MEM, 32'd6);
    check("stfwd_cnt", 32'(fwd_count), 32'(exp_cnt));

    // Freeze three cycles with changing inputs
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val1_EXE = 32'd100 + 32'(i); EXE_CMD = 4'd1; dest_EXE = 5'd7 + 5'(i);
      MEM_W_EN_EXE = 1'b0; WB_EN_EXE = 1'b0; ST_val_EXE = 32'hABC0 + 32'(i);
      val1_sel = 2'd1; val2_sel = 2'd1; ST_val_sel = 2'd1;
      tick();
      check("frz_alu",  ALU_res_MEM, 32'd6);
      check("frz_st",   ST_val_MEM, FWD ? 32'hDEAD_BEEF : 32'h55);
      check("frz_dest", 32'(dest_MEM), 32'd3);
      check("frz_mw",   32'(MEM_W_EN_MEM), 32'd1);
      check("frz_cnt",  32'(fwd_count), 32'(exp_cnt));
    end

    // Flush wins over freeze
    flush = 1'b1; WB_EN_EXE = 1'b1; MEM_W_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b1;
    tick();
    check("fl_wb",   32'(WB_EN_MEM), 32'd0);
    check("fl_mw",   32'(MEM_W_EN_MEM), 32'd0);
    check("fl_mr",   32'(MEM_R_EN_MEM), 32'd0);
    check("fl_alu",  ALU_res_MEM, 32'd0);
    check("fl_dest", 32'(dest_MEM), 32'd0);
    check("fl_st",   ST_val_MEM, 32'd0);
    check("fl_cnt",  32'(fwd_count), 32'(exp_cnt));
    flush = 1'b0; freeze = 1'b0;
    val1_sel = 2'd0; val2_sel = 2'd0; ST_val_sel = 2'd0;

    // ALU operations and edge cases
    check_alu(4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, "sra");
    check_alu(4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, "sub");
    check_alu(4'd12, 32'h1234_5678, 32'h1,         32'h0,         "cmd12");
    check_alu(4'd6,  32'd1,         32'h3F,        32'h8000_0000, "sll");
    check_alu(4'd8,  32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
    check_alu(4'd4,  32'h0,         32'h0,         32'hFFFF_FFFF, "nor");
    check_alu(4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
    check_alu(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
    check_alu(4'd3,  32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, "or");
    check_alu(4'd0,  32'hFFFF_FFFF, 32'd2,         32'h1,         "add_wrap");
    check("alu_cnt", 32'(fwd_count), 32'(exp_cnt));

    // Mid-operation reset overrides freeze and flush
    rst = 1'b0; freeze = 1'b1; flush = 1'b1;
    tick();
    check("mrst_alu", ALU_res_MEM, 32'h0);
    check("mrst_cnt", 32'(fwd_count), 32'h0);
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;

    // Saturation: 21844*3 + 2 = 0xFFFE, then +3 clamps at 0xFFFF
    val1_sel = 2'd1; val2_sel = 2'd1; ST_val_sel = 2'd1;
    for (int i = 0; i < 21844; i++) tick();
    check("sat_pre", 32'(fwd_count), FWD ? 32'd65532 : 32'd0);
    ST_val_sel = 2'd3;
    tick();
    check("sat_fffe", 32'(fwd_count), FWD ? 32'hFFFE : 32'd0);
    ST_val_sel = 2'd1;
    tick();
    check("sat_ffff", 32'(fwd_count), FWD ? 32'hFFFF : 32'd0);
    tick();
    check("sat_hold", 32'(fwd_count), FWD ? 32'hFFFF : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
